serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller. Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It then sequences a single one-bit full-adder cell, built from two gate-level half adders, over WIDTH clock cycles, LSB first. It returns the sum, carry-out and signed overflow over a second valid/ready handshake. It is the area-minimal arithmetic engine for the gate-level datapath, trading latency for a single adder cell.

## Interface
- WIDTH, default 8: operand/sum width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  controller can accept operands.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state: IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch a and b into shift registers, latch cin into the carry FF, clear the bit counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each edge: the cell adds a_sr[0], b_sr[0] and carry.
  - The sum bit shifts into the MSB of sum_sr. a_sr and b_sr shift right. The carry FF takes the cell carry-out. The counter increments.
  - On the edge that processes bit WIDTH-1 (counter==WIDTH-1):
    - Capture ovf = carry_in_to_msb ^ cell_cout.
    - Capture cout = cell_cout.
    - Go to DONE.
- DONE:
  - out_valid=1. sum, cout and ovf are stable and held.
  - On out_valid&out_ready: go to IDLE.
- Arithmetic:
  - sum is exactly (a+b+cin) mod 2^WIDTH.
  - {cout,sum} equals the full WIDTH+1-bit sum.
  - ovf is meaningful for two's-complement operands.
- in_valid while busy: ignored, no state change. The upstream holds its data until in_ready.
- out_ready asserted before DONE: no effect.
- in_valid is not required to stay high after the handshake. Operands are captured on the accept edge.

## Timing
- Reset (async assert, synchronous deassert expected upstream):
  - State=IDLE, in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0, ovf=0. Counter, shift registers and carry FF are 0.
- Reset mid-RUN or in DONE: the operation is aborted and the result is discarded. No out_valid is produced for it.
- Latency: accept edge T. out_valid rises after edge T+WIDTH. Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH RUN edges, output handshake, return to IDLE).
- in_ready rises in the cycle after the output handshake. There is no same-cycle result-out/operand-in overlap.
- Outputs are registered. There are no combinational paths from in_valid or out_ready to any output except through state registers.
- Counter width: $clog2(WIDTH). It wraps to 0 only via the IDLE→RUN clear and never free-runs.

## Structure
- Shared package `serial_add_pkg`:
  - State enum constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Constant MAX_WIDTH=32.
- Sub-module `full_add_cell` (a, b, ci → s, co): two gate-level half adders plus an OR gate. It is instantiated once.
- The top level holds the FSM, counter, shift registers, carry FF and output registers. No other hierarchy.

## Test plan
- Reset, then check outputs. Then apply WIDTH=8, a=0x0F, b=0x01, cin=0 → after 8 cycles out_valid=1, sum=0x10, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum/cout/ovf stable, in_ready=0. Toggle in_valid with a new operand throughout → it is ignored. Release out_ready → IDLE on the next edge, and the pending operand is then accepted.
- Assert rst_n=0 at RUN bit 4 → all outputs return to reset values immediately. After release, a new a=0x03, b=0x05 → sum=0x08 with correct latency.
- Random 1000 operand pairs at WIDTH=8 and WIDTH=16 with random in_valid/out_ready gaps → every result matches {cout,sum}=a+b+cin. Exactly one result per accepted input.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and width limit.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/full_add_cell.sv
// One-bit full adder assembled from two gate-level half adders and an OR gate.
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    // First half adder combines the operand bits, second folds in the carry.
    assign ha0_s = a ^ b;
    assign ha0_c = a & b;
    assign s     = ha0_s ^ ci;
    assign ha1_c = ha0_s & ci;
    assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: shifts operands LSB-first through a single full-adder cell over WIDTH cycles.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid-side data holds until then.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic cell_s;
    logic cell_co;

    full_add_cell u_cell (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sr_d = {cell_s, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = cell_co;
                // The counter parks on the last index so it only returns to 0 on the next accept.
                if (cnt_q == LAST) begin
                    cout_d  = cell_co;
                    ovf_d   = carry_q ^ cell_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_sr_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid8, out_ready8, cin8;
  logic [7:0] a8, b8;
  logic       in_ready8, out_valid8, cout8, ovf8, busy8;
  logic [7:0] sum8;
  logic [1:0] st8;

  logic        in_valid16, out_ready16, cin16;
  logic [15:0] a16, b16;
  logic        in_ready16, out_valid16, cout16, ovf16, busy16;
  logic [15:0] sum16;
  logic [1:0]  st16;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8), .state_dbg(st8)
  );

  serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16), .state_dbg(st16)
  );

  bit w16 = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [33:0] exp_q[$];

  logic        m_in_ready, m_out_valid, m_cout, m_ovf, m_busy;
  logic [31:0] m_sum;
  logic [1:0]  m_state;

  always_comb begin
    m_in_ready  = w16 ? in_ready16  : in_ready8;
    m_out_valid = w16 ? out_valid16 : out_valid8;
    m_cout      = w16 ? cout16      : cout8;
    m_ovf       = w16 ? ovf16       : ovf8;
    m_busy      = w16 ? busy16      : busy8;
    m_sum       = w16 ? {16'b0, sum16} : {24'b0, sum8};
    m_state     = w16 ? st16        : st8;
  end

  function automatic int cur_w();
    return w16 ? 16 : 8;
  endfunction

  // Result packed as {ovf, cout, sum}
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
    logic [32:0] mask;
    logic [32:0] full;
    logic [31:0] s;
    logic co;
    logic ov;
    mask = (33'd1 << w) - 33'd1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'b0, c};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  function automatic logic [33:0] mk(input logic [31:0] s, input logic c, input logic o);
    return {o, c, s};
  endfunction

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c);
    if (w16) begin
      in_valid16 = v; a16 = a[15:0]; b16 = b[15:0]; cin16 = c;
    end else begin
      in_valid8 = v; a8 = a[7:0]; b8 = b[7:0]; cin8 = c;
    end
  endtask

  task automatic set_out_ready(input logic r);
    if (w16) out_ready16 = r;
    else out_ready8 = r;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, m_in_ready, 1);
    check({tag, "_out_valid"}, m_out_valid, 0);
    check({tag, "_busy"}, m_busy, 0);
    check({tag, "_sum"}, m_sum, 0);
    check({tag, "_cout"}, m_cout, 0);
    check({tag, "_ovf"}, m_ovf, 0);
    check({tag, "_state"}, m_state, 0);
  endtask

  // Holds in_valid until the controller takes the operands; returns just after the accept edge.
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic c);
    bit ok = 1'b0;
    set_in(1'b1, a, b, c);
    for (int i = 0; i < 200; i++) begin
      if (m_in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    set_in(1'b0, '0, '0, 1'b0);
    check("accept_handshake", ok, 1);
  endtask

  task automatic wait_result(input bit lat, input logic [33:0] e);
    bit seen = 1'b0;
    if (lat) begin
      for (int i = 1; i < cur_w(); i++) begin
        tick();
        check("no_early_valid", m_out_valid, 0);
      end
      tick();
      check("valid_at_latency", m_out_valid, 1);
    end else begin
      for (int i = 0; i < 200; i++) begin
        tick();
        if (m_out_valid) begin
          set_out_ready(1'b0);
          set_in(1'b0, '0, '0, 1'b0);
          seen = 1'b1;
          break;
        end
        // Noise while busy: early out_ready and stray operands must both be ignored.
        set_out_ready(1'($urandom_range(0, 1)));
        set_in(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      check("result_arrived", seen, 1);
    end
    check("sum", m_sum, e[31:0]);
    check("cout", m_cout, e[32]);
    check("ovf", m_ovf, e[33]);
  endtask

  task automatic release_out();
    set_out_ready(1'b1);
    tick();
    set_out_ready(1'b0);
    check("single_result", m_out_valid, 0);
    check("ready_after_release", m_in_ready, 1);
  endtask

  logic [31:0] dir_a [5] = '{32'h0F, 32'hFF, 32'hFF, 32'h7F, 32'h80};
  logic [31:0] dir_b [5] = '{32'h01, 32'h01, 32'hFF, 32'h01, 32'h80};
  logic        dir_c [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [33:0] dir_e [5];

  initial begin
    logic [31:0] ra, rb;
    logic rc;
    logic [33:0] e;

    dir_e[0] = mk(32'h10, 1'b0, 1'b0);
    dir_e[1] = mk(32'h00, 1'b1, 1'b0);
    dir_e[2] = mk(32'hFF, 1'b1, 1'b0);
    dir_e[3] = mk(32'h80, 1'b0, 1'b1);
    dir_e[4] = mk(32'h00, 1'b1, 1'b1);

    rst_n = 1'b0;
    in_valid8 = 0; out_ready8 = 0; cin8 = 0; a8 = '0; b8 = '0;
    in_valid16 = 0; out_ready16 = 0; cin16 = 0; a16 = '0; b16 = '0;
    repeat (3) tick();
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_reset_values("post_reset");

    for (int i = 0; i < 5; i++) begin
      accept(dir_a[i], dir_b[i], dir_c[i]);
      check("busy_in_run", m_busy, 1);
      wait_result(1'b1, dir_e[i]);
      release_out();
    end

    // Backpressure with a pending operand bundle
    accept(32'h11, 32'h22, 1'b0);
    wait_result(1'b1, mk(32'h33, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      set_in(1'(i % 2 == 0), 32'h12, 32'h34, 1'b0);
      tick();
      check("bp_hold_sum", m_sum, 32'h33);
      check("bp_hold_valid", m_out_valid, 1);
      check("bp_in_ready_low", m_in_ready, 0);
    end
    set_in(1'b1, 32'h12, 32'h34, 1'b0);
    set_out_ready(1'b1);
    tick();
    set_out_ready(1'b0);
    check("bp_release_idle", m_in_ready, 1);
    check("bp_release_valid", m_out_valid, 0);
    tick();
    set_in(1'b0, '0, '0, 1'b0);
    check("bp_pending_accepted", m_busy, 1);
    wait_result(1'b1, mk(32'h46, 1'b0, 1'b0));
    release_out();

    // Reset in the middle of RUN
    accept(32'h0F, 32'h0F, 1'b0);
    repeat (4) tick();
    check("busy_before_abort", m_busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    accept(32'h03, 32'h05, 1'b0);
    wait_result(1'b1, mk(32'h08, 1'b0, 1'b0));
    release_out();

    for (int pass = 0; pass < 2; pass++) begin
      w16 = (pass == 1);
      for (int n = 0; n < 1000; n++) begin
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 3)) tick();
        exp_q.push_back(model(cur_w(), ra, rb, rc));
        accept(ra, rb, rc);
        e = exp_q.pop_front();
        wait_result(1'b0, e);
        repeat ($urandom_range(0, 3)) begin
          tick();
          check("rand_hold_sum", m_sum, e[31:0]);
        end
        release_out();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
